// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: access sizes, arbiter states,
// requester ids and the memory request bundle driven onto the memory port.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } size_e;

   typedef enum logic {
      ARB       = 1'b0,
      DMA_BURST = 1'b1
   } arb_state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_id_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      size_e       write_size;
      size_e       read_size;
      logic        sign_ext;
      logic [31:0] pc;
   } mem_req_t;

   localparam mem_req_t MEM_REQ_IDLE = '0;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
      return (v < lim) ? v + 4'd1 : lim;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields, ready
// handshake and the registered read response.
interface dmem_arbiter_if;

   logic                req_valid;
   logic                req_ready;
   logic [31:0]         addr;
   logic [31:0]         wdata;
   dmem_arb_pkg::size_e write_size;
   dmem_arb_pkg::size_e read_size;
   logic                sign_ext;
   logic [31:0]         pc;
   logic                resp_valid;
   logic [31:0]         rdata;

   modport master (
      output req_valid, addr, wdata, write_size, read_size, sign_ext, pc,
      input  req_ready, resp_valid, rdata
   );

   modport slave (
      input  req_valid, addr, wdata, write_size, read_size, sign_ext, pc,
      output req_ready, resp_valid, rdata
   );

endinterface

// File: rtl/dmem_arbiter_req_mux.sv
// Selects the granted requester's fields onto the memory port; with no grant
// every field is zero so the memory performs no access.
module dmem_arb_req_mux
   import dmem_arb_pkg::*;
(
   input  logic     gnt_vld,
   input  req_id_e  gnt_id,
   input  mem_req_t cpu_req,
   input  mem_req_t dma_req,
   output mem_req_t mem_req
);

   always_comb begin
      mem_req = MEM_REQ_IDLE;
      if (gnt_vld) begin
         if (gnt_id == REQ_CPU) begin
            mem_req = cpu_req;
         end else begin
            // the trace PC only ever belongs to the pipeline
            mem_req    = dma_req;
            mem_req.pc = '0;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority, DMA starvation guard and a
// locked DMA burst mode. Define DMEM_ARB_TRACE_EN for a simulation write trace.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_BURST    = 16
) (
   input  logic        clock,
   input  logic        reset,
   dmem_arbiter_if.slave cpu,
   dmem_arbiter_if.slave dma,
   input  logic        dma_req_last,
   output logic        dma_burst_abort,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output size_e       mem_write_size,
   output size_e       mem_read_size,
   output logic        mem_read_sign_extend,
   output logic [31:0] mem_pc,
   input  logic [31:0] mem_dout
);

   localparam int             BW         = $clog2(MAX_BURST + 1);
   localparam logic [3:0]     STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [BW-1:0]  BEAT_MAX   = BW'(MAX_BURST);

   arb_state_e    state, state_n;
   logic [3:0]    starve_cnt, starve_n;
   logic [BW-1:0] beat_cnt, beat_n, beat_inc;
   logic          abort_n;
   logic          cpu_rdy, dma_rdy;
   logic          cpu_rd, dma_rd;
   logic          cpu_rv_q, dma_rv_q;
   logic [31:0]   cpu_rd_q, dma_rd_q;
   mem_req_t      cpu_req, dma_req, mem_req;

   assign beat_inc = beat_cnt + BW'(1);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state           <= ARB;
         starve_cnt      <= '0;
         beat_cnt        <= '0;
         dma_burst_abort <= 1'b0;
      end else begin
         state           <= state_n;
         starve_cnt      <= starve_n;
         beat_cnt        <= beat_n;
         dma_burst_abort <= abort_n;
      end
   end

   // Nothing is granted while reset is held, so no write lands during reset.
   always_comb begin
      state_n = state;
      beat_n  = beat_cnt;
      abort_n = 1'b0;
      cpu_rdy = 1'b0;
      dma_rdy = 1'b0;
      if (reset) begin
         case (state)
            ARB: begin
               if (cpu.req_valid && (starve_cnt < STARVE_MAX)) cpu_rdy = 1'b1;
               else                                            dma_rdy = dma.req_valid;
               if (dma_rdy && !dma_req_last) begin
                  state_n = DMA_BURST;
                  beat_n  = BW'(1);
               end
            end
            DMA_BURST: begin
               dma_rdy = dma.req_valid;
               if (dma_rdy) begin
                  if (dma_req_last) begin
                     state_n = ARB;
                     beat_n  = '0;
                  end else if (beat_inc == BEAT_MAX) begin
                     state_n = ARB;
                     beat_n  = '0;
                     abort_n = 1'b1;
                  end else begin
                     beat_n  = beat_inc;
                  end
               end
            end
            default: state_n = ARB;
         endcase
      end
      starve_n = (!dma.req_valid || dma_rdy) ? 4'd0 : sat_inc4(starve_cnt, STARVE_MAX);
   end

   assign cpu.req_ready = cpu_rdy;
   assign dma.req_ready = dma_rdy;

   assign cpu_req = '{addr: cpu.addr, wdata: cpu.wdata, write_size: cpu.write_size,
                      read_size: cpu.read_size, sign_ext: cpu.sign_ext, pc: cpu.pc};
   assign dma_req = '{addr: dma.addr, wdata: dma.wdata, write_size: dma.write_size,
                      read_size: dma.read_size, sign_ext: dma.sign_ext, pc: dma.pc};

   dmem_arb_req_mux u_req_mux (
      .gnt_vld (cpu_rdy || dma_rdy),
      .gnt_id  (cpu_rdy ? REQ_CPU : REQ_DMA),
      .cpu_req (cpu_req),
      .dma_req (dma_req),
      .mem_req (mem_req)
   );

   assign mem_addr             = mem_req.addr;
   assign mem_din              = mem_req.wdata;
   assign mem_write_size       = mem_req.write_size;
   assign mem_read_size        = mem_req.read_size;
   assign mem_read_sign_extend = mem_req.sign_ext;
   assign mem_pc               = mem_req.pc;

   assign cpu_rd = cpu_rdy && (cpu.read_size != SZ_NONE);
   assign dma_rd = dma_rdy && (dma.read_size != SZ_NONE);

   // rdata holds its last value between responses
   always_ff @(posedge clock) begin
      if (!reset) begin
         cpu_rv_q <= 1'b0;
         dma_rv_q <= 1'b0;
         cpu_rd_q <= '0;
         dma_rd_q <= '0;
      end else begin
         cpu_rv_q <= cpu_rd;
         dma_rv_q <= dma_rd;
         if (cpu_rd) cpu_rd_q <= mem_dout;
         if (dma_rd) dma_rd_q <= mem_dout;
      end
   end

   assign cpu.resp_valid = cpu_rv_q;
   assign cpu.rdata      = cpu_rd_q;
   assign dma.resp_valid = dma_rv_q;
   assign dma.rdata      = dma_rd_q;

`ifdef DMEM_ARB_TRACE_EN
   always @(posedge clock) begin
      if (reset && (mem_write_size != SZ_NONE))
         $display("%s @%08h: %08h <= %08h", cpu_rdy ? "C" : "D", mem_pc, mem_addr, mem_din);
      if (reset && abort_n)
         $display("WARNING dmem_arbiter: DMA burst released after %0d beats", MAX_BURST);
   end
`else
   // trace output compiled out
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed check of dmem_arbiter against a rule-level model
// with its own shadow memory; the bench also plays the memory device.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int SL = 4;
   localparam int MB = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   dmem_arbiter_if cpu_if();
   dmem_arbiter_if dma_if();

   logic        dma_req_last;
   logic        dma_burst_abort;
   logic [31:0] mem_addr, mem_din, mem_pc, mem_dout;
   size_e       mem_write_size, mem_read_size;
   logic        mem_read_sign_extend;

   dmem_arbiter #(.STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
      .clock                (clock),
      .reset                (reset),
      .cpu                  (cpu_if),
      .dma                  (dma_if),
      .dma_req_last         (dma_req_last),
      .dma_burst_abort      (dma_burst_abort),
      .mem_addr             (mem_addr),
      .mem_din              (mem_din),
      .mem_write_size       (mem_write_size),
      .mem_read_size        (mem_read_size),
      .mem_read_sign_extend (mem_read_sign_extend),
      .mem_pc               (mem_pc),
      .mem_dout             (mem_dout)
   );

   typedef struct {
      bit          v;
      logic [31:0] a, wd, pc;
      size_e       ws, rs;
      bit          sx;
   } rq_t;

   function automatic logic [31:0] pat(input int i);
      return (i == 4) ? 32'h80FF_FFFF : {i[7:0], 8'hA5, 8'(i * 7), 8'h3C};
   endfunction

   function automatic logic [31:0] rd(input logic [31:0] w, input logic [31:0] a,
                                      input size_e s, input bit sx);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * a[1:0]));
      h = 16'(w >> (16 * a[1]));
      case (s)
         SZ_BYTE: return sx ? {{24{b[7]}}, b} : {24'd0, b};
         SZ_HALF: return sx ? {{16{h[15]}}, h} : {16'd0, h};
         SZ_WORD: return w;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] wr(input logic [31:0] old, input logic [31:0] a,
                                      input logic [31:0] d, input size_e s);
      logic [31:0] r;
      r = old;
      case (s)
         SZ_BYTE: r[8 * a[1:0] +: 8]  = d[7:0];
         SZ_HALF: r[16 * a[1] +: 16]  = d[15:0];
         SZ_WORD: r                   = d;
         default: ;
      endcase
      return r;
   endfunction

   function automatic rq_t mk(input bit v, input logic [31:0] a, input logic [31:0] wd,
                              input size_e ws, input size_e rs, input bit sx,
                              input logic [31:0] pc);
      rq_t r;
      r.v = v; r.a = a; r.wd = wd; r.ws = ws; r.rs = rs; r.sx = sx; r.pc = pc;
      return r;
   endfunction

   // memory device: combinational read, write at posedge, pattern on reset
   logic [31:0] mem [64];
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= pat(i);
      end else if (mem_write_size != SZ_NONE) begin
         mem[mem_addr[7:2]] <= wr(mem[mem_addr[7:2]], mem_addr, mem_din, mem_write_size);
      end
   end
   always_comb mem_dout = rd(mem[mem_addr[7:2]], mem_addr, mem_read_size, mem_read_sign_extend);

   // reference model state
   logic [31:0] ref_mem [64];
   bit          m_lock;
   int          m_beats, m_wait;
   bit          e_crv, e_drv, e_abort;
   logic [31:0] e_crd, e_drd;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
      m_lock = 1'b0; m_beats = 0; m_wait = 0;
      e_crv = 1'b0; e_drv = 1'b0; e_abort = 1'b0;
      e_crd = '0; e_drd = '0;
   endtask

   // one clock cycle: drive, check against the model, advance the model
   task automatic step(input bit rst, input rq_t c, input rq_t d, input bit last,
                       output bit oc, output bit od, output bit oab);
      bit          gc, gd;
      rq_t         g;
      @(negedge clock);
      reset = rst;
      cpu_if.req_valid = c.v;  cpu_if.addr = c.a;  cpu_if.wdata = c.wd;
      cpu_if.write_size = c.ws; cpu_if.read_size = c.rs; cpu_if.sign_ext = c.sx; cpu_if.pc = c.pc;
      dma_if.req_valid = d.v;  dma_if.addr = d.a;  dma_if.wdata = d.wd;
      dma_if.write_size = d.ws; dma_if.read_size = d.rs; dma_if.sign_ext = d.sx; dma_if.pc = d.pc;
      dma_req_last = last;
      #1;
      chk("cpu_resp_valid", 32'(cpu_if.resp_valid), 32'(e_crv));
      chk("cpu_rdata",      cpu_if.rdata,           e_crd);
      chk("dma_resp_valid", 32'(dma_if.resp_valid), 32'(e_drv));
      chk("dma_rdata",      dma_if.rdata,           e_drd);
      chk("dma_burst_abort", 32'(dma_burst_abort),  32'(e_abort));

      gc = rst && !m_lock && c.v && (m_wait < SL);
      gd = rst && !gc && d.v;
      g  = mk(1'b0, '0, '0, SZ_NONE, SZ_NONE, 1'b0, '0);
      if (gc) g = c;
      else if (gd) begin g = d; g.pc = '0; end
      chk("cpu_req_ready", 32'(cpu_if.req_ready), 32'(gc));
      chk("dma_req_ready", 32'(dma_if.req_ready), 32'(gd));
      chk("mem_addr",       mem_addr,              g.a);
      chk("mem_din",        mem_din,               g.wd);
      chk("mem_write_size", 32'(mem_write_size),   32'(g.ws));
      chk("mem_read_size",  32'(mem_read_size),    32'(g.rs));
      chk("mem_sign_ext",   32'(mem_read_sign_extend), 32'(g.sx));
      chk("mem_pc",         mem_pc,                g.pc);
      oc = cpu_if.req_ready; od = dma_if.req_ready; oab = dma_burst_abort;

      if (!rst) begin
         model_reset();
      end else begin
         e_crv = gc && (c.rs != SZ_NONE);
         e_drv = gd && (d.rs != SZ_NONE);
         if (e_crv) e_crd = rd(ref_mem[c.a[7:2]], c.a, c.rs, c.sx);
         if (e_drv) e_drd = rd(ref_mem[d.a[7:2]], d.a, d.rs, d.sx);
         if ((gc || gd) && g.ws != SZ_NONE)
            ref_mem[g.a[7:2]] = wr(ref_mem[g.a[7:2]], g.a, g.wd, g.ws);
         m_wait  = (!d.v || gd) ? 0 : ((m_wait < SL) ? m_wait + 1 : SL);
         e_abort = 1'b0;
         if (gd) begin
            if (!m_lock) begin
               if (!last) begin m_lock = 1'b1; m_beats = 1; end
            end else begin
               m_beats++;
               if (last) begin m_lock = 1'b0; m_beats = 0; end
               else if (m_beats == MB) begin m_lock = 1'b0; m_beats = 0; e_abort = 1'b1; end
            end
         end
      end
   endtask

   function automatic rq_t rnd_rq();
      return mk($urandom_range(0, 9) < 7, 32'($urandom_range(0, 255)), $urandom,
                size_e'($urandom_range(0, 3)), size_e'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rq_t idle, crd, drd, dwr;
      bit  oc, od, oab;
      int  k, cnt, g, ab;

      idle = mk(1'b0, '0, '0, SZ_NONE, SZ_NONE, 1'b0, '0);
      crd  = mk(1'b1, 32'h10, '0, SZ_NONE, SZ_WORD, 1'b0, 32'h0000_0404);
      drd  = mk(1'b1, 32'h20, '0, SZ_NONE, SZ_WORD, 1'b0, 32'hDEAD_0000);
      cpu_if.req_valid = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
      cpu_if.write_size = SZ_NONE; cpu_if.read_size = SZ_NONE; cpu_if.sign_ext = 1'b0; cpu_if.pc = '0;
      dma_if.req_valid = 1'b0; dma_if.addr = '0; dma_if.wdata = '0;
      dma_if.write_size = SZ_NONE; dma_if.read_size = SZ_NONE; dma_if.sign_ext = 1'b0; dma_if.pc = '0;
      dma_req_last = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);

      // reset state, with requests present but reset held
      step(1'b0, crd, drd, 1'b1, oc, od, oab);
      step(1'b0, idle, idle, 1'b1, oc, od, oab);

      // sub-word signed byte read
      step(1'b1, mk(1'b1, 32'h13, '0, SZ_NONE, SZ_BYTE, 1'b1, 32'h400), idle, 1'b1, oc, od, oab);
      step(1'b1, idle, idle, 1'b1, oc, od, oab);
      chk("subword_rdata", cpu_if.rdata, 32'hFFFF_FF80);

      // priority
      step(1'b1, crd, drd, 1'b1, oc, od, oab);
      chk("prio_cpu_gnt", 32'(oc), 32'd1);
      chk("prio_dma_wait", 32'(od), 32'd0);
      step(1'b1, idle, drd, 1'b1, oc, od, oab);
      chk("prio_rdata", cpu_if.rdata, 32'h80FF_FFFF);
      chk("prio_dma_gnt", 32'(od), 32'd1);

      // starvation guard
      k = -1;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, crd, drd, 1'b1, oc, od, oab);
         if (od && k < 0) k = i;
         if (i == 5) chk("starve_cpu_resume", 32'(oc), 32'd1);
      end
      chk("starve_dma_cycle", 32'(k), 32'd4);
      step(1'b1, idle, idle, 1'b1, oc, od, oab);

      // locked burst of three writes; first beat forced through by the guard
      dwr = mk(1'b1, 32'h100, 32'h1111_0000, SZ_WORD, SZ_NONE, 1'b0, 32'h0);
      cnt = 0;
      do begin step(1'b1, crd, dwr, 1'b0, oc, od, oab); cnt++; end while (!od && cnt < 8);
      chk("burst_force_cycles", 32'(cnt), 32'd5);
      chk("burst_b1_cpu", 32'(oc), 32'd0);
      dwr.a = 32'h104; dwr.wd = 32'h2222_0004;
      step(1'b1, crd, dwr, 1'b0, oc, od, oab);
      chk("burst_b2_cpu", 32'(oc), 32'd0);
      dwr.a = 32'h108; dwr.wd = 32'h3333_0008;
      step(1'b1, crd, dwr, 1'b1, oc, od, oab);
      chk("burst_b3_cpu", 32'(oc), 32'd0);
      chk("burst_b3_dma", 32'(od), 32'd1);
      step(1'b1, crd, idle, 1'b1, oc, od, oab);
      chk("burst_cpu_after", 32'(oc), 32'd1);
      step(1'b1, mk(1'b1, 32'h104, '0, SZ_NONE, SZ_WORD, 1'b0, 32'h8), idle, 1'b1, oc, od, oab);
      step(1'b1, idle, idle, 1'b1, oc, od, oab);
      chk("burst_wr_readback", cpu_if.rdata, 32'h2222_0004);

      // burst abort at MAX_BURST
      cnt = 0;
      do begin step(1'b1, crd, drd, 1'b0, oc, od, oab); cnt++; end while (!od && cnt < 8);
      chk("abort_force", 32'(od), 32'd1);
      g = 0; ab = 0;
      for (int j = 0; j < 5; j++) begin
         drd.a = 32'h40 + 32'(4 * j);
         step(1'b1, crd, drd, 1'b0, oc, od, oab);
         g += int'(od); ab += int'(oab);
         if (j == 3) chk("abort_cpu_next", 32'(oc), 32'd1);
      end
      chk("abort_beats", 32'(g), 32'd3);
      chk("abort_pulses", 32'(ab), 32'd1);
      step(1'b1, idle, idle, 1'b1, oc, od, oab);

      // reset during beat 2 of a burst
      dwr.a = 32'h80;
      cnt = 0;
      do begin step(1'b1, crd, dwr, 1'b0, oc, od, oab); cnt++; end while (!od && cnt < 8);
      chk("rstmid_force", 32'(od), 32'd1);
      step(1'b0, crd, drd, 1'b0, oc, od, oab);
      step(1'b1, idle, idle, 1'b1, oc, od, oab);
      chk("rstmid_resp", 32'(dma_if.resp_valid), 32'd0);
      chk("rstmid_wsize", 32'(mem_write_size), 32'd0);
      step(1'b1, crd, drd, 1'b0, oc, od, oab);
      chk("rstmid_arb", 32'(oc), 32'd1);

      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 63) != 0, rnd_rq(), rnd_rq(), $urandom_range(0, 3) == 0,
              oc, od, oab);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/debug loader (DMA).
- One memory access per cycle.
- Memory read is combinational; memory write lands at the next posedge.
- The arbiter registers read data and returns it one cycle after grant.
- CPU has priority, with a starvation guard for DMA and a locked DMA burst mode.

Parameters:
STARVE_LIMIT, 4, consecutive cycles DMA may wait while CPU wins before DMA is forced through (1..15).
MAX_BURST, 16, maximum beats in one locked DMA burst before forced release (2..256).

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-low reset
cpu_req_valid  in  1  CPU access request
cpu_req_ready  out  1  CPU request accepted this cycle (combinational)
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_write_size  in  2  0 none, 1 byte, 2 half, 3 word
cpu_read_size  in  2  same encoding
cpu_sign_ext  in  1  sign-extend sub-word reads
cpu_pc  in  32  PC of the access, forwarded for trace
cpu_resp_valid  out  1  read data valid, one-cycle pulse
cpu_rdata  out  32  registered read data
dma_req_valid, dma_req_ready, dma_addr, dma_wdata, dma_write_size, dma_read_size, dma_sign_ext, dma_resp_valid, dma_rdata  as CPU equivalents
dma_req_last  in  1  final beat of a DMA burst (1 = single access)
dma_burst_abort  out  1  one-cycle pulse when MAX_BURST forces release
mem_addr  out  32  to memory
mem_din  out  32  to memory
mem_write_size  out  2  to memory
mem_read_size  out  2  to memory
mem_read_sign_extend  out  1  to memory
mem_pc  out  32  cpu_pc when CPU granted, else 0
mem_dout  in  32  combinational read data from memory

Behaviour:
Reset and idle outputs:
- Reset (reset=0 at posedge): state=ARB, starve_cnt=0, beat_cnt=0.
- All resp_valid=0, rdata=0, dma_burst_abort=0.
- With no grant, all mem_* outputs are 0, so no access occurs.

Handshake:
- A transfer occurs when req_valid && req_ready.
- ready is combinational and asserted to at most one requester per cycle.
- The granted requester's fields drive mem_* in the same cycle.

Read response:
- If the granted read_size!=0, mem_dout is captured into that requester's rdata at posedge.
- resp_valid pulses the following cycle.
- Writes produce no response.
- A request with both sizes nonzero performs both, as the memory does.
- A size-0/0 request is accepted and produces no response.

State ARB:
- CPU wins if cpu_req_valid && starve_cnt<STARVE_LIMIT; otherwise DMA wins if dma_req_valid.
- starve_cnt increments (saturating at STARVE_LIMIT) each cycle dma_req_valid && !dma_req_ready.
- starve_cnt clears on a DMA grant, or whenever dma_req_valid=0.
- DMA grant with dma_req_last=0 -> DMA_BURST, beat_cnt=1.

State DMA_BURST:
- cpu_req_ready=0; dma_req_ready=dma_req_valid.
- DMA valid dropping mid-burst leaves idle cycles and stays in DMA_BURST.
- Each DMA transfer increments beat_cnt.
- A transfer with dma_req_last=1 -> ARB, beat_cnt=0.
- A transfer making beat_cnt==MAX_BURST with last=0 -> ARB, dma_burst_abort pulses the next cycle, starve_cnt=0.

Reset mid-burst returns to ARB immediately and drops any pending response.

Optional Feature:
DMEM_ARB_TRACE_EN:
- When defined, each granted write prints "[C|D] @pc: addr <= wdata" via $display at posedge.
- Each burst abort prints a warning.
- When undefined, no simulation output; RTL is otherwise identical.

Decomposition:
Package dmem_arb_pkg holds:
- size_e (SZ_NONE=0, SZ_BYTE=1, SZ_HALF=2, SZ_WORD=3).
- arb_state_e (ARB, DMA_BURST).
- req_id_e (REQ_CPU, REQ_DMA).
- mem_req_t struct (addr, wdata, write_size, read_size, sign_ext, pc).

One sub-module, dmem_arb_req_mux: combinational select of mem_req_t by grant, zeroing outputs when no grant.

Test Plan:
- Priority: CPU read word 0x10 and DMA read 0x20 both valid, starve_cnt=0 -> CPU granted; cpu_resp_valid next cycle with mem[0x10]; DMA waits.
- Starvation guard: CPU and DMA continuously valid, STARVE_LIMIT=4 -> DMA granted on the 5th cycle, starve_cnt=0 afterward; CPU resumes the next cycle.
- Locked burst: DMA writes 3 beats 0x100/0x104/0x108, last on beat 3, with CPU valid throughout -> cpu_req_ready=0 for all 3 beats; CPU granted the cycle after beat 3.
- Burst abort: MAX_BURST=4, DMA issues 5 beats with last=0 -> 4 accepted; dma_burst_abort pulses once; CPU granted next.
- Sub-word read: CPU byte read 0x13, sign_ext=1, mem word 0x80FFFFFF -> cpu_rdata=0xFFFFFF80.
- Reset mid-burst: reset low during beat 2 -> next cycle state ARB, all resp_valid=0, mem_write_size=0.
